// File: rtl/bayer_edge_pipe.sv
// Streaming Bayer-quad to grayscale converter followed by a 3x3 Sobel edge stage.
// Three register stages: gray -> window/gradients -> abs/clamp/mode mux.
module bayer_edge_pipe #(
  parameter int DATA_W  = 12,
  parameter int BAYER_W = 1280,
  parameter int BAYER_H = 960,
  parameter int SAT_MAX = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic              oSOF
);

  localparam int GW  = BAYER_W / 2;
  localparam int CW  = $clog2(BAYER_W);
  localparam int RW  = $clog2(BAYER_H);
  localparam int GCW = CW - 1;
  localparam int GRW = RW - 1;
  localparam int SW  = DATA_W + 4;
  localparam int AW  = DATA_W + 5;

  function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] x);
    return $signed({4'b0000, x});
  endfunction

  logic [CW-1:0]      col_r;
  logic [RW-1:0]      row_r;
  logic [1:0]         mode_r;
  logic               act_r;
  logic               sof_beat_s;
  logic               beat_s;
  logic               quad_s;
  logic [CW-1:0]      col_s;
  logic [RW-1:0]      row_s;
  logic [1:0]         mode_s;

  // Beats are ignored after reset until a frame is opened by iSOF
  always_comb begin
    sof_beat_s = iDVAL & iSOF;
    beat_s     = iDVAL & (act_r | iSOF);
    col_s      = sof_beat_s ? '0 : col_r;
    row_s      = sof_beat_s ? '0 : row_r;
    mode_s     = sof_beat_s ? iMODE : mode_r;
    quad_s     = beat_s & row_s[0] & col_s[0];
  end

  // Raster position counters and per-frame mode latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r  <= '0;
      row_r  <= '0;
      mode_r <= 2'd0;
      act_r  <= 1'b0;
    end else if (beat_s) begin
      act_r  <= 1'b1;
      mode_r <= mode_s;
      if (col_s == CW'(BAYER_W - 1)) begin
        col_r <= '0;
        row_r <= (row_s == RW'(BAYER_H - 1)) ? '0 : row_s + RW'(1);
      end else begin
        col_r <= col_s + CW'(1);
        row_r <= row_s;
      end
    end
  end

  logic [DATA_W-1:0] lb_mem [BAYER_W];
  logic [DATA_W-1:0] up_s;
  logic [DATA_W-1:0] up_d_r;
  logic [DATA_W-1:0] cur_d_r;
  logic [DATA_W+1:0] qsum_s;
  logic [DATA_W-1:0] gray_s;

  assign up_s   = lb_mem[col_s];
  assign qsum_s = {2'b00, up_d_r} + {2'b00, up_s} + {2'b00, cur_d_r} + {2'b00, iDATA};
  assign gray_s = DATA_W'(qsum_s >> 2);

  // Previous Bayer line; contents are never cleared, stale data is masked by position
  always_ff @(posedge clk) begin
    if (beat_s) begin
      lb_mem[col_s] <= iDATA;
    end
  end

  // One-pixel delays complete the 2x2 quad
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_d_r  <= '0;
      cur_d_r <= '0;
    end else if (beat_s) begin
      up_d_r  <= up_s;
      cur_d_r <= iDATA;
    end
  end

  logic              v1_r;
  logic              sof1_r;
  logic              en1_r;
  logic [1:0]        mode1_r;
  logic [GCW-1:0]    gcol1_r;
  logic [DATA_W-1:0] gray1_r;

  // Stage 1: gray value of the completed quad
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      sof1_r  <= 1'b0;
      en1_r   <= 1'b0;
      mode1_r <= 2'd0;
      gcol1_r <= '0;
      gray1_r <= '0;
    end else begin
      v1_r <= quad_s;
      if (quad_s) begin
        sof1_r  <= (row_s[RW-1:1] == GRW'(0)) && (col_s[CW-1:1] == GCW'(0));
        en1_r   <= (row_s[RW-1:1] >= GRW'(2)) && (col_s[CW-1:1] >= GCW'(2));
        mode1_r <= mode_s;
        gcol1_r <= col_s[CW-1:1];
        gray1_r <= gray_s;
      end
    end
  end

  logic [DATA_W-1:0]        gl0_mem [GW];
  logic [DATA_W-1:0]        gl1_mem [GW];
  logic [DATA_W-1:0]        top_s;
  logic [DATA_W-1:0]        mid_s;
  logic [DATA_W-1:0]        sh0_r [3];
  logic [DATA_W-1:0]        sh1_r [3];
  logic signed [SW-1:0]     gx_s;
  logic signed [SW-1:0]     gy_s;

  assign top_s = gl0_mem[gcol1_r];
  assign mid_s = gl1_mem[gcol1_r];

  // Window rows: 0 = sh/top (oldest), 1 = mid, 2 = current gray; column 2 is the newest
  assign gx_s = (ext(top_s) + (ext(mid_s) <<< 1) + ext(gray1_r))
              - (ext(sh0_r[0]) + (ext(sh0_r[1]) <<< 1) + ext(sh0_r[2]));
  assign gy_s = (ext(sh0_r[2]) + (ext(sh1_r[2]) <<< 1) + ext(gray1_r))
              - (ext(sh0_r[0]) + (ext(sh1_r[0]) <<< 1) + ext(top_s));

  // Two gray lines roll upward as each new gray pixel arrives
  always_ff @(posedge clk) begin
    if (v1_r) begin
      gl0_mem[gcol1_r] <= mid_s;
      gl1_mem[gcol1_r] <= gray1_r;
    end
  end

  logic                 v2_r;
  logic                 sof2_r;
  logic                 en2_r;
  logic [1:0]           mode2_r;
  logic [DATA_W-1:0]    gray2_r;
  logic signed [SW-1:0] gx_r;
  logic signed [SW-1:0] gy_r;

  // Stage 2: column shift and gradient registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r    <= 1'b0;
      sof2_r  <= 1'b0;
      en2_r   <= 1'b0;
      mode2_r <= 2'd0;
      gray2_r <= '0;
      gx_r    <= '0;
      gy_r    <= '0;
      for (int i = 0; i < 3; i++) begin
        sh0_r[i] <= '0;
        sh1_r[i] <= '0;
      end
    end else begin
      v2_r   <= v1_r;
      sof2_r <= v1_r & sof1_r;
      if (v1_r) begin
        en2_r    <= en1_r;
        mode2_r  <= mode1_r;
        gray2_r  <= gray1_r;
        gx_r     <= gx_s;
        gy_r     <= gy_s;
        sh0_r[0] <= sh1_r[0];
        sh0_r[1] <= sh1_r[1];
        sh0_r[2] <= sh1_r[2];
        sh1_r[0] <= top_s;
        sh1_r[1] <= mid_s;
        sh1_r[2] <= gray1_r;
      end
    end
  end

  logic [SW-1:0]     ax_s;
  logic [SW-1:0]     ay_s;
  logic [AW-1:0]     edge_s;
  logic [DATA_W-1:0] clip_s;
  logic [DATA_W-1:0] res_s;

  // Stage 3 combinational: magnitude, saturation and output select
  always_comb begin
    ax_s   = gx_r[SW-1] ? $unsigned(-gx_r) : $unsigned(gx_r);
    ay_s   = gy_r[SW-1] ? $unsigned(-gy_r) : $unsigned(gy_r);
    edge_s = '0;
    case (mode2_r)
      2'd1:    edge_s = {1'b0, ax_s};
      2'd2:    edge_s = {1'b0, ay_s};
      2'd3:    edge_s = {1'b0, ax_s} + {1'b0, ay_s};
      default: edge_s = '0;
    endcase
    if (edge_s > AW'(SAT_MAX)) begin
      clip_s = DATA_W'(SAT_MAX);
    end else begin
      clip_s = edge_s[DATA_W-1:0];
    end
    if (mode2_r == 2'd0) begin
      res_s = gray2_r;
    end else if (en2_r) begin
      res_s = clip_s;
    end else begin
      res_s = '0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oDATA <= '0;
      oDVAL <= 1'b0;
      oSOF  <= 1'b0;
    end else begin
      oDVAL <= v2_r;
      oSOF  <= v2_r & sof2_r;
      if (v2_r) begin
        oDATA <= res_s;
      end
    end
  end

endmodule

// File: tb/tb_bayer_edge_pipe.sv
// Directed bench for bayer_edge_pipe on an 8x8 Bayer frame (4x4 gray grid),
// with a second instance at SAT_MAX=4095 sharing the same input stream.
module tb_bayer_edge_pipe;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic          iSOF;
  logic [1:0]    iMODE;
  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic          oSOF;
  logic [DW-1:0] o2_data;
  logic          o2_dval;
  logic          o2_sof;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          q11_cyc = 0;
  int          expv [20];
  logic [31:0] out_q [$];
  logic [31:0] sof_q [$];
  logic [31:0] out2_q [$];
  int          ocyc_q [$];

  bayer_edge_pipe #(.DATA_W(DW), .BAYER_W(8), .BAYER_H(8), .SAT_MAX(2048)) u_dut (
    .clk(clk), .rst(rst), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF), .iMODE(iMODE),
    .oDATA(oDATA), .oDVAL(oDVAL), .oSOF(oSOF)
  );

  bayer_edge_pipe #(.DATA_W(DW), .BAYER_W(8), .BAYER_H(8), .SAT_MAX(4095)) u_dut_sat (
    .clk(clk), .rst(rst), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF), .iMODE(iMODE),
    .oDATA(o2_data), .oDVAL(o2_dval), .oSOF(o2_sof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every result strobe on the falling edge
  always @(negedge clk) begin
    if (oDVAL === 1'b1) begin
      out_q.push_back(32'(oDATA));
      sof_q.push_back(32'(oSOF));
      ocyc_q.push_back(cyc);
    end
    if (o2_dval === 1'b1) begin
      out2_q.push_back(32'(o2_data));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic v, input logic s, input logic [1:0] m);
    @(posedge clk);
    #1;
    iDATA = d;
    iDVAL = v;
    iSOF  = s;
    iMODE = m;
  endtask

  function automatic logic [DW-1:0] pix(input int pat, input int val, input int r, input int c);
    case (pat)
      1:       return (c < 4) ? DW'(4 * (1 + 2 * (r % 2) + (c % 2))) : DW'(4095);
      2:       return (c < 4) ? DW'(0) : DW'(1000);
      3:       return ((c / 2) > (r / 2)) ? DW'(4095) : DW'(0);
      default: return DW'(val);
    endcase
  endfunction

  task automatic send(input int pat, input int val, input logic [1:0] mode, input int nbeats,
                      input bit gaps, input bit tog);
    for (int b = 0; b < nbeats; b++) begin
      int r = b / 8;
      int c = b % 8;
      if (gaps) repeat ($urandom_range(0, 2)) drive('0, 1'b0, 1'b0, mode);
      drive(pix(pat, val, r, c), 1'b1, b == 0, (tog && b != 0) ? 2'(b) : mode);
      if (r == 1 && c == 1) q11_cyc = cyc;
    end
    drive('0, 1'b0, 1'b0, mode);
  endtask

  task automatic drain();
    repeat (8) drive('0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic clear_q();
    out_q.delete();
    sof_q.delete();
    out2_q.delete();
    ocyc_q.delete();
  endtask

  task automatic fill_edge(input int v);
    for (int i = 0; i < 16; i++) expv[i] = (i / 4 >= 2 && i % 4 >= 2) ? v : 0;
  endtask

  task automatic check_frame(input string tag, input int n, input int nsof);
    int s = 0;
    chk({tag, "_count"}, out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++)
      chk($sformatf("%s_px%0d", tag, i), out_q[i], expv[i]);
    foreach (sof_q[i]) s += int'(sof_q[i]);
    chk({tag, "_sofcount"}, s, nsof);
    chk({tag, "_sof_first"}, (sof_q.size() > 0) ? sof_q[0] : 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; iDATA = '0; iDVAL = 1'b0; iSOF = 1'b0; iMODE = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_odata", oDATA, 0);
    chk("reset_odval", oDVAL, 0);
    chk("reset_osof", oSOF, 0);
    chk("reset_odval_sat", o2_dval, 0);
    rst = 1'b0;

    // Flat gray, mode 0, latency from the row1/col1 beat
    clear_q(); send(0, 100, 2'd0, 64, 1'b0, 1'b0); drain();
    for (int i = 0; i < 16; i++) expv[i] = 100;
    check_frame("t1_flat", 16, 1);
    chk("t1_latency", (ocyc_q.size() > 0) ? ocyc_q[0] - q11_cyc : -1, 3);
    chk("t1_sat_count", out2_q.size(), 16);

    // Quad averaging and full-scale quads
    clear_q(); send(1, 0, 2'd0, 64, 1'b0, 1'b0); drain();
    for (int i = 0; i < 16; i++) expv[i] = (i % 4 < 2) ? 10 : 4095;
    check_frame("t2_avg", 16, 1);

    // Gx on a vertical step, clamped at 2048 (4000 unclamped on the 4095 instance)
    clear_q(); send(2, 0, 2'd1, 64, 1'b0, 1'b0); drain();
    fill_edge(2048);
    check_frame("t3_gx", 16, 1);
    chk("t3_sat_unclamped", (out2_q.size() > 10) ? out2_q[10] : 32'd0, 32'd4000);

    // |Gx|+|Gy| on a diagonal step
    clear_q(); send(3, 0, 2'd3, 64, 1'b0, 1'b0); drain();
    fill_edge(2048);
    check_frame("t4_diag2048", 16, 1);
    out_q = out2_q;
    fill_edge(4095);
    check_frame("t4_diag4095", 16, 1);

    // Gy on a vertical-only step is zero everywhere
    clear_q(); send(2, 0, 2'd2, 64, 1'b0, 1'b0); drain();
    fill_edge(0);
    check_frame("t4_gy_vert", 16, 1);

    // iMODE wiggles mid-frame, mode 1 captured at iSOF must hold
    clear_q(); send(2, 0, 2'd1, 64, 1'b0, 1'b1); drain();
    fill_edge(2048);
    check_frame("t5_modehold", 16, 1);

    // Frame abandoned at row 3 by a new iSOF
    clear_q(); send(0, 50, 2'd0, 24, 1'b0, 1'b0); send(0, 200, 2'd0, 64, 1'b0, 1'b0); drain();
    for (int i = 0; i < 20; i++) expv[i] = (i < 4) ? 50 : 200;
    check_frame("t5_restart", 20, 2);
    chk("t5_restart_sof4", (sof_q.size() > 4) ? sof_q[4] : 32'd0, 32'd1);

    // Random iDVAL gaps reproduce the gap-free results
    clear_q(); send(2, 0, 2'd1, 64, 1'b1, 1'b0); drain();
    fill_edge(2048);
    check_frame("t6_gaps", 16, 1);

    // Reset while results are in flight
    clear_q();
    for (int b = 0; b <= 27; b++) drive(DW'(100), 1'b1, b == 0, 2'd0);
    @(posedge clk);
    #2;
    chk("t6_busy_before_rst", oDVAL, 1);
    rst = 1'b1;
    #1;
    chk("t6_odval_at_rst", oDVAL, 0);
    clear_q();
    repeat (2) drive('0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    for (int b = 0; b < 20; b++) drive(DW'(100), 1'b1, 1'b0, 2'd0);
    drain();
    chk("t6_no_stale", out_q.size(), 0);
    clear_q(); send(0, 100, 2'd0, 64, 1'b0, 1'b0); drain();
    for (int i = 0; i < 16; i++) expv[i] = 100;
    check_frame("t6_after_rst", 16, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
